// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared register-writeback types and constants.
package reg_wb_pkg;
    localparam int WB_PORTS = 2;
    localparam int WB_DATA_WIDTH = 32;
    typedef logic [4:0] reg_addr_t;
    typedef struct packed {
        reg_addr_t                addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/reg_wb_late_fifo.sv
// reg_wb_late_fifo: late-result FIFO, one push and up to two pops per cycle, head and head+1 visible.
module reg_wb_late_fifo
    import reg_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  logic [4:0]                  push_addr_i,
    input  logic [DATA_WIDTH-1:0]       push_data_i,
    input  logic [1:0]                  pop_i,
    output logic [4:0]                  head0_addr_o,
    output logic [DATA_WIDTH-1:0]       head0_data_o,
    output logic [4:0]                  head1_addr_o,
    output logic [DATA_WIDTH-1:0]       head1_data_o,
    output logic [$clog2(DEPTH):0]      count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    reg_addr_t             addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q, rd_ptr_1;
    logic [CW-1:0]         count_q;
    assign rd_ptr_1     = rd_ptr_q + PW'(1);
    assign head0_addr_o = addr_q[rd_ptr_q];
    assign head0_data_o = data_q[rd_ptr_q];
    assign head1_addr_o = addr_q[rd_ptr_1];
    assign head1_data_o = data_q[rd_ptr_1];
    assign count_o      = count_q;
    // storage needs no reset; only pointers and count define validity
    always_ff @(posedge clk) begin
        if (push_i) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end
    // pointers wrap naturally modulo DEPTH; count tracks push minus pops
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push_i);
            rd_ptr_q <= rd_ptr_q + PW'(pop_i);
            count_q  <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end
endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: merges two in-order lanes and a buffered late stream onto two regfile write ports.
// Optional REG_WB_STAT_EN adds saturating late-stall and late-writeback counters.
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LATE_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                lane_valid_i,
    input  logic [9:0]                lane_addr_i,
    input  logic [2*DATA_WIDTH-1:0]   lane_data_i,
    input  logic                      late_valid_i,
    output logic                      late_ready_o,
    input  logic [4:0]                late_addr_i,
    input  logic [DATA_WIDTH-1:0]     late_data_i,
    output logic [1:0]                w_en_o,
    output logic [9:0]                w_addr_o,
    output logic [2*DATA_WIDTH-1:0]   w_data_o,
    output logic                      late_pending_o
`ifdef REG_WB_STAT_EN
    ,
    output logic [31:0]               stat_late_stall_o,
    output logic [31:0]               stat_late_wb_o
`endif
);
    localparam int CW = $clog2(LATE_DEPTH) + 1;
    logic [CW-1:0]           count;
    logic [4:0]              head0_addr, head1_addr;
    logic [DATA_WIDTH-1:0]   head0_data, head1_data;
    logic                    push, use0, use1;
    logic [1:0]              pop;
    logic [4:0]              addr0_d, addr1_d;
    logic [DATA_WIDTH-1:0]   data0_d, data1_d;
    logic [1:0]              w_en_d, w_en_q;
    logic [9:0]              w_addr_q;
    logic [2*DATA_WIDTH-1:0] w_data_q;
    assign late_ready_o   = count != CW'(LATE_DEPTH);
    assign late_pending_o = count != '0;
    assign push           = late_valid_i & late_ready_o;
    assign w_en_o         = w_en_q;
    assign w_addr_o       = w_addr_q;
    assign w_data_o       = w_data_q;
    reg_wb_late_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(LATE_DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_addr_i  (late_addr_i),
        .push_data_i  (late_data_i),
        .pop_i        (pop),
        .head0_addr_o (head0_addr),
        .head0_data_o (head0_data),
        .head1_addr_o (head1_addr),
        .head1_data_o (head1_data),
        .count_o      (count)
    );
    // lanes own their port; idle ports take FIFO entries oldest-first, lowest port first
    always_comb begin
        use0    = ~lane_valid_i[0] & (count != '0);
        use1    = ~lane_valid_i[1] & (lane_valid_i[0] ? count != '0 : count > CW'(1));
        pop     = {1'b0, use0} + {1'b0, use1};
        addr0_d = lane_valid_i[0] ? lane_addr_i[4:0] : use0 ? head0_addr : '0;
        data0_d = lane_valid_i[0] ? lane_data_i[DATA_WIDTH-1:0] : use0 ? head0_data : '0;
        addr1_d = lane_valid_i[1] ? lane_addr_i[9:5] : use1 ? (lane_valid_i[0] ? head0_addr : head1_addr) : '0;
        data1_d = lane_valid_i[1] ? lane_data_i[2*DATA_WIDTH-1:DATA_WIDTH] : use1 ? (lane_valid_i[0] ? head0_data : head1_data) : '0;
        // idle ports carry address 0, so a nonzero address implies a real non-r0 write
        w_en_d  = {|addr1_d, |addr0_d & (addr0_d != addr1_d)};
    end
    // register the selected writes; port1 wins a same-address collision as the younger write
    always_ff @(posedge clk) begin
        if (rst) begin
            w_en_q   <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            w_en_q   <= w_en_d;
            w_addr_q <= {addr1_d, addr0_d};
            w_data_q <= {data1_d, data0_d};
        end
    end
`ifdef REG_WB_STAT_EN
    logic [31:0] stall_q, wb_q;
    logic [32:0] wb_sum;
    assign wb_sum            = {1'b0, wb_q} + {31'b0, pop};
    assign stat_late_stall_o = stall_q;
    assign stat_late_wb_o    = wb_q;
    // saturating counts of refused late offers and late entries drained to the ports
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            wb_q    <= '0;
        end else begin
            if (late_valid_i & ~late_ready_o & ~&stall_q) stall_q <= stall_q + 32'd1;
            wb_q <= wb_sum[32] ? '1 : wb_sum[31:0];
        end
    end
`endif
endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Writeback-side producer for the 2-write-port register file. It drives the 4r2w regfile's write addresses, data and enables.
- Merges two in-order pipeline lanes (fixed-latency results) with one out-of-order "late" result stream (divider / cache-miss load) through a small buffer.
- Late results fill only those write ports that are idle in a given cycle.
- Sits between the execute/memory stages and the register file.

Parameters:
- DATA_WIDTH, 32, width of result data.
- LATE_DEPTH, 2, late-result buffer entries (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- lane_valid_i  in  2  lane k carries a result this cycle.
- lane_addr_i  in  2x5  lane destination register.
- lane_data_i  in  2xDATA_WIDTH  lane result.
- late_valid_i  in  1  late result offered.
- late_ready_o  out  1  late result accepted when valid&ready.
- late_addr_i  in  5  late destination register.
- late_data_i  in  DATA_WIDTH  late result.
- w_en_o  out  2  regfile write enables.
- w_addr_o  out  2x5  regfile write addresses.
- w_data_o  out  2xDATA_WIDTH  regfile write data.
- late_pending_o  out  1  buffer non-empty (stalls retire of dependent ops).

Behaviour:
- Reset: w_en_o=0, w_addr_o=0, w_data_o=0, buffer empty (count=0, pointers=0), late_ready_o=1, late_pending_o=0.
- Lane k always has priority on port k; lanes have no backpressure.
- Lane path latency is 1 cycle: inputs sampled at edge E appear on w_*_o in the cycle after E.
- Late handshake:
  - A transfer occurs at an edge where late_valid_i & late_ready_o. The entry is pushed into the FIFO.
  - late_ready_o = (count != LATE_DEPTH). It is registered-state based and does not depend on late_valid_i.
  - late_valid_i while not ready: no push. The producer must hold its data.
- Port allocation (combinational, from current lane inputs and FIFO state):
  - A port is free iff lane_valid_i[k]=0.
  - FIFO pops min(free ports, count) entries.
  - The oldest entry goes to the lowest-numbered free port; a second entry goes to port1 only when both ports are free.
  - The selection is registered into w_*_o at the same edge as the pop.
- Late path minimum latency is 2 cycles: accepted at E0, written on w_*_o in the cycle after E1.
- A late input is never bypassed directly to the ports; it always passes through the FIFO.
- Push and pop at the same edge are allowed. Count updates by (push - pops). When full, a pop in that cycle does not enable a push the same cycle, because ready is state-based.
- Register r0 writes:
  - A lane or late entry with addr 0 is consumed normally but produces w_en_o=0 on its port.
  - w_addr_o/w_data_o still carry the entry's values.
- Same-address collision: if both output ports are enabled with equal addresses, port0 enable is suppressed (port1 is the younger write).
- Late entries never address-conflict with same-cycle lane writes; the upstream scoreboard guarantees this.
- late_pending_o = (count != 0), taken from registered state.
- Pointers wrap modulo LATE_DEPTH. Count width is clog2(LATE_DEPTH)+1.
- Reset asserted mid-operation discards all buffered late entries and clears outputs on that edge. The producer must re-issue.

Optional Feature:
- Macro: REG_WB_STAT_EN.
- Defined:
  - Adds 32-bit saturating counters stat_late_stall_o (cycles with late_valid_i & ~late_ready_o) and stat_late_wb_o (late entries written).
  - Both counters clear on rst.
  - Adds output ports stat_late_stall_o and stat_late_wb_o.
- Undefined: no counters and no extra ports; core behaviour is identical.

Decomposition:
- Shared package reg_wb_pkg contains:
  - typedef reg_addr_t (5-bit) and wb_entry_t {addr, data}.
  - localparam WB_PORTS=2.
- One natural sub-module: reg_wb_late_fifo, a parameterised FIFO with multi-pop (0..2) per cycle, exposing the head and head+1 entries and count.

Test Plan:
- Lanes only: lane0 (r3, 0x11) and lane1 (r4, 0x22) at cycle 0 -> w_en_o=2'b11, w_addr_o={4,3}, w_data_o={0x22,0x11} at cycle 1. No late activity; late_ready_o stays 1.
- Late fill: lanes idle, late (r7, 0xAB) accepted at cycle 0 -> cycle 2 shows w_en_o=2'b01, w_addr_o[0]=7; late_pending_o is 1 in cycle 1 and 0 in cycle 2.
- Backpressure: lanes both valid continuously, 3 late offers -> two accepted, late_ready_o=0 afterwards. Drop lane1 for one cycle -> oldest entry appears on port1, ready returns to 1 next cycle.
- Dual drain: buffer holds (r5, 1) then (r6, 2), lanes idle -> one cycle later port0 = r5/1 and port1 = r6/2, buffer empty.
- Corner cases:
  - lane0 and lane1 both target r9 -> only w_en_o[1]=1.
  - lane0 targets r0 -> w_en_o[0]=0.
  - rst asserted with a full buffer -> all outputs 0, late_ready_o=1 next cycle.
- With REG_WB_STAT_EN: 5 stalled cycles plus 3 late writebacks -> stat_late_stall_o=5, stat_late_wb_o=3.
